mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single unified memory port between two requesters: instruction fetch (IF stage) and data access (MEM stage).
- Arbitrates between them and sequences a request/acknowledge transaction on the memory side.
- Returns read data and acknowledge to the winner. The hazard unit turns the unanswered requester into a stall.
- Data accesses have priority. A starvation counter guarantees fetch progress, and a timeout protects against a memory that never acknowledges.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables are DATA_W/8)
STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced to win (1..15)
TIMEOUT, 255, cycles in BUSY without m_ack before abort; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr stable until if_ack
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetch read data, valid while if_ack=1
if_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  data request; held with d_* stable until d_ack
d_we  in  1  1=write, 0=read
d_be  in  DATA_W/8  byte enables
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  data read data, valid while d_ack=1
d_ack  out  1  one-cycle data completion pulse
m_req  out  1  memory request; held until m_ack or timeout
m_we  out  1  memory write enable
m_be  out  DATA_W/8  memory byte enables
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, valid with m_ack
m_ack  in  1  memory completion, sampled only while m_req=1
owner  out  1  current/last grant: 0=fetch, 1=data
timeout_err  out  1  pulses together with the ack of an aborted transaction

Behaviour:
- All outputs are registered.
- Reset (rst_n low, any time, including mid-transaction):
  - state=IDLE; starve_cnt=0; timer=0.
  - All outputs are 0, including m_req, both acks, rdata, m_* and owner.
  - An in-flight transaction is dropped silently.
- States: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise arbitrate at the clock edge:
    - Data wins if d_req=1, unless if_req=1 and starve_cnt==STARVE_LIMIT, in which case fetch wins.
    - Fetch wins if only if_req=1.
  - The winner's fields are latched into m_*. For fetch: m_we=0, m_be=all ones, m_wdata=0.
  - Then m_req<=1, owner<=winner, go to BUSY.
- Starve counter:
  - Increments on a data grant while if_req=1, saturating at STARVE_LIMIT.
  - Clears on a fetch grant, and in any IDLE cycle with if_req=0.
- BUSY:
  - m_req=1 and m_* are held constant.
  - timer increments every cycle.
  - On m_ack=1: capture m_rdata into the owner's rdata (writes also capture m_rdata; the requester ignores it). Then m_req<=0, owner's ack<=1, go to RESP.
  - If TIMEOUT!=0 and timer reaches TIMEOUT-1 with no m_ack:
    - m_req<=0, owner's rdata<=0, owner's ack<=1, timeout_err<=1, go to RESP.
    - A late m_ack arriving after m_req drops is ignored.
- RESP:
  - Lasts exactly one cycle; ack (and timeout_err if set) are high only here.
  - Requests are not arbitrated in RESP, so the acknowledged requester's still-high req is never regranted.
  - Next state is IDLE; ack, timeout_err and timer clear.
- Latency:
  - req sampled at edge k, m_req high from k+1.
  - m_ack seen at edge j gives ack high in cycle j+1.
  - Minimum transaction (m_ack in the first BUSY cycle) is 3 cycles, IDLE→BUSY→RESP.
- Rules:
  - rdata holds its value after the ack until the next completion for that side.
  - m_ack outside BUSY is ignored.
  - Requester fields may change only after ack. A request withdrawn before grant is legal; once granted it completes.

Test Plan:
- Fetch alone: if_req=1, if_addr=0x10, m_ack one cycle after m_req with m_rdata=0x00500093 → m_addr=0x10, m_we=0, m_be=0xF; if_ack one cycle later with if_rdata=0x00500093; owner=0; 3 cycles total.
- Data write alone: d_we=1, d_be=0x3, d_addr=0x200, d_wdata=0xDEADBEEF → m_* carry those values, d_ack pulses once, if_ack stays 0.
- Both requesting together: d_req and if_req both 1 from reset → data granted first (owner=1); fetch granted in the IDLE cycle after d_ack.
- Starvation, STARVE_LIMIT=4: d_req re-asserted for 6 back-to-back transactions while if_req is held → grant order D,D,D,D,I,D.
- Timeout, TIMEOUT=8: never drive m_ack → m_req drops after 8 BUSY cycles; d_ack=1, timeout_err=1, d_rdata=0. A late m_ack pulse is ignored.
- Reset mid-BUSY: assert rst_n=0 asynchronously while m_req=1 → m_req, acks and owner go to 0 immediately. After release, a new fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one unified memory port between instruction fetch (IF) and data
// access (MEM). Data has priority. A starvation counter forces a fetch grant
// after STARVE_LIMIT consecutive data grants made while fetch was waiting.
// A BUSY-state timer aborts a transaction that memory never acknowledges.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   if_req/if_addr               fetch request side
//   if_rdata/if_ack              fetch response (ack is a one-cycle pulse)
//   d_req/d_we/d_be/d_addr/d_wdata  data request side
//   d_rdata/d_ack                data response (ack is a one-cycle pulse)
//   m_req/m_we/m_be/m_addr/m_wdata  memory request, held until ack or abort
//   m_rdata/m_ack                memory response
//   owner                        current/last grant: 0=fetch, 1=data
//   timeout_err                  pulses with the ack of an aborted transaction
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_ack,
  output logic                  m_req,
  output logic                  m_we,
  output logic [DATA_W/8-1:0]   m_be,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ack,
  output logic                  owner,
  output logic                  timeout_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST   = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : {TMR_W{1'b0}};
  localparam logic             TMO_EN     = (TIMEOUT != 0);
  localparam logic [3:0]       STARVE_LIM = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [BE_W-1:0]     m_be_q, m_be_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic                owner_q, owner_d;
  logic                if_ack_q, if_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                timeout_err_q, timeout_err_d;
  logic                grant_data_s;

  // Data wins unless fetch is waiting and has been passed over STARVE_LIMIT times.
  assign grant_data_s = d_req && !(if_req && (starve_cnt_q == STARVE_LIM));

  // Next-state, arbitration, timer and response computation.
  always_comb begin
    state_d       = state_q;
    starve_cnt_d  = starve_cnt_q;
    timer_d       = timer_q;
    m_req_d       = m_req_q;
    m_we_d        = m_we_q;
    m_be_d        = m_be_q;
    m_addr_d      = m_addr_q;
    m_wdata_d     = m_wdata_q;
    owner_d       = owner_q;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    if_ack_d      = 1'b0;
    d_ack_d       = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = {TMR_W{1'b0}};
        if (if_req || d_req) begin
          state_d = ST_BUSY;
          m_req_d = 1'b1;
          owner_d = grant_data_s;
          if (grant_data_s) begin
            m_we_d    = d_we;
            m_be_d    = d_be;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            // Only a data grant that bypasses a waiting fetch counts toward starvation.
            if (!if_req) begin
              starve_cnt_d = 4'd0;
            end else if (starve_cnt_q < STARVE_LIM) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end else begin
              starve_cnt_d = STARVE_LIM;
            end
          end else begin
            m_we_d       = 1'b0;
            m_be_d       = {BE_W{1'b1}};
            m_addr_d     = if_addr;
            m_wdata_d    = {DATA_W{1'b0}};
            starve_cnt_d = 4'd0;
          end
        end else begin
          starve_cnt_d = 4'd0;
        end
      end

      ST_BUSY: begin
        if (m_ack) begin
          m_req_d = 1'b0;
          state_d = ST_RESP;
          timer_d = timer_q + TMR_W'(1'b1);
          if (owner_q) begin
            d_rdata_d = m_rdata;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = m_rdata;
            if_ack_d   = 1'b1;
          end
        end else if (TMO_EN && (timer_q == TMR_LAST)) begin
          // Abort: hand the owner a zero word flagged with timeout_err.
          m_req_d       = 1'b0;
          state_d       = ST_RESP;
          timeout_err_d = 1'b1;
          timer_d       = timer_q;
          if (owner_q) begin
            d_rdata_d = {DATA_W{1'b0}};
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = {DATA_W{1'b0}};
            if_ack_d   = 1'b1;
          end
        end else if (TMO_EN) begin
          timer_d = timer_q + TMR_W'(1'b1);
        end else begin
          timer_d = timer_q;
        end
      end

      ST_RESP: begin
        // No arbitration here, so the just-acknowledged req cannot be regranted.
        state_d = ST_IDLE;
        timer_d = {TMR_W{1'b0}};
      end

      default: begin
        state_d = ST_IDLE;
        m_req_d = 1'b0;
        timer_d = {TMR_W{1'b0}};
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      starve_cnt_q  <= 4'd0;
      timer_q       <= {TMR_W{1'b0}};
      m_req_q       <= 1'b0;
      m_we_q        <= 1'b0;
      m_be_q        <= {BE_W{1'b0}};
      m_addr_q      <= {ADDR_W{1'b0}};
      m_wdata_q     <= {DATA_W{1'b0}};
      owner_q       <= 1'b0;
      if_rdata_q    <= {DATA_W{1'b0}};
      d_rdata_q     <= {DATA_W{1'b0}};
      if_ack_q      <= 1'b0;
      d_ack_q       <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      timer_q       <= timer_d;
      m_req_q       <= m_req_d;
      m_we_q        <= m_we_d;
      m_be_q        <= m_be_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      owner_q       <= owner_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      if_ack_q      <= if_ack_d;
      d_ack_q       <= d_ack_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign m_req       = m_req_q;
  assign m_we        = m_we_q;
  assign m_be        = m_be_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign owner       = owner_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_ack      = if_ack_q;
  assign d_ack       = d_ack_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (STARVE_LIMIT=4, TIMEOUT=8).
// Reference model: a word memory array, a starvation count derived from the
// grant history, and per-side "last returned word" values.
module tb_mem_port_arbiter;

  localparam int SL = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = 4'h0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = 32'h0;
  logic        m_ack = 1'b0;
  logic        owner;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  int          starve_m = 0;
  logic [31:0] mem [16];
  logic [31:0] exp_if_rdata = 32'h0;
  logic [31:0] exp_d_rdata  = 32'h0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_req"}, 64'(m_req), 64'd0);
    chk({tag, "_m_we"}, 64'(m_we), 64'd0);
    chk({tag, "_m_be"}, 64'(m_be), 64'd0);
    chk({tag, "_m_addr"}, 64'(m_addr), 64'd0);
    chk({tag, "_m_wdata"}, 64'(m_wdata), 64'd0);
    chk({tag, "_if_ack"}, 64'(if_ack), 64'd0);
    chk({tag, "_d_ack"}, 64'(d_ack), 64'd0);
    chk({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
    chk({tag, "_d_rdata"}, 64'(d_rdata), 64'd0);
    chk({tag, "_owner"}, 64'(owner), 64'd0);
    chk({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
  endtask

  // Idle cycle with nothing granted: an IDLE cycle without fetch clears starvation.
  task automatic idle_cycle();
    if (!if_req) starve_m = 0;
    @(negedge clk);
  endtask

  // One complete transaction. delay<0: memory never acks (timeout expected).
  // Called at a negedge with requests already presented; returns winner (1=data).
  task automatic serve(input int delay, output int winner);
    logic        exp_d;
    logic [31:0] e_addr, e_wdata, rd;
    logic [3:0]  e_be;
    logic        e_we;
    int          n, busy;
    exp_d = d_req && !(if_req && starve_m == SL);
    if (exp_d) begin
      e_we = d_we; e_be = d_be; e_addr = d_addr; e_wdata = d_wdata;
      starve_m = if_req ? ((starve_m < SL) ? starve_m + 1 : SL) : 0;
    end else begin
      e_we = 1'b0; e_be = 4'hF; e_addr = if_addr; e_wdata = 32'h0;
      starve_m = 0;
    end
    winner = int'(exp_d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_req !== 1'b1 && n < 8);
    chk("grant_latency", 64'(n), 64'd1);
    if (m_req === 1'b1) begin
      chk("owner", 64'(owner), 64'(exp_d));
      chk("m_we", 64'(m_we), 64'(e_we));
      chk("m_be", 64'(m_be), 64'(e_be));
      chk("m_addr", 64'(m_addr), 64'(e_addr));
      chk("m_wdata", 64'(m_wdata), 64'(e_wdata));
      rd = mem[e_addr[5:2]];
      busy = 0;
      while (1) begin
        if (delay >= 0 && busy == delay) begin
          m_ack = 1'b1; m_rdata = rd;
        end else begin
          m_ack = 1'b0; m_rdata = $urandom;
        end
        @(negedge clk);
        busy++;
        if (m_req !== 1'b1 || busy > TO + 2) break;
        chk("busy_hold_addr", 64'(m_addr), 64'(e_addr));
        chk("busy_no_ack", 64'({if_ack, d_ack}), 64'd0);
      end
      if (delay < 0) begin
        chk("timeout_len", 64'(busy), 64'(TO));
        rd = 32'h0;
        m_ack = 1'b1;            // late ack during RESP must be ignored
        m_rdata = $urandom;
      end else begin
        chk("ack_len", 64'(busy), 64'(delay + 1));
        m_ack = 1'b0;
      end
      chk("resp_m_req", 64'(m_req), 64'd0);
      chk("resp_if_ack", 64'(if_ack), 64'(!exp_d));
      chk("resp_d_ack", 64'(d_ack), 64'(exp_d));
      chk("resp_timeout_err", 64'(timeout_err), 64'(delay < 0));
      if (exp_d) exp_d_rdata = rd; else exp_if_rdata = rd;
      chk("resp_if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
      chk("resp_d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
      if (delay >= 0 && exp_d && e_we) begin
        for (int b = 0; b < 4; b++)
          if (e_be[b]) mem[e_addr[5:2]][8*b +: 8] = e_wdata[8*b +: 8];
      end
      @(negedge clk);
      chk("post_acks", 64'({if_ack, d_ack, timeout_err}), 64'd0);
      chk("post_no_regrant", 64'(m_req), 64'd0);
      m_ack = 1'b0;
    end
    if (exp_d) d_req = 1'b0; else if_req = 1'b0;
  endtask

  initial begin
    int w;
    int exp_order [6];
    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch alone
    mem[4] = 32'h00500093;
    if_req = 1'b1; if_addr = 32'h10;
    serve(0, w);
    chk("fetch_winner", 64'(w), 64'd0);
    chk("fetch_rdata_hold", 64'(if_rdata), 64'h00500093);

    // Data write alone
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    serve(1, w);
    chk("write_winner", 64'(w), 64'd1);

    // Both together: data first, fetch immediately after
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h14;
    serve(0, w);
    chk("both_first", 64'(w), 64'd1);
    serve(2, w);
    chk("both_second", 64'(w), 64'd0);

    // Starvation: fetch held across 6 data requests
    exp_order = '{1, 1, 1, 1, 0, 1};
    if_req = 1'b1; if_addr = 32'h20;
    for (int k = 0; k < 6; k++) begin
      if (!d_req) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
        d_addr = {26'h0, 4'($urandom), 2'b00}; d_wdata = $urandom;
      end
      if (!if_req) begin
        if_req = 1'b1; if_addr = 32'h24;
      end
      serve($urandom_range(0, 2), w);
      chk($sformatf("starve_order_%0d", k), 64'(w), 64'(exp_order[k]));
    end
    serve(0, w);
    chk("starve_drain", 64'(w), 64'd0);

    // Timeout on a data read
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h8; d_wdata = 32'h0;
    serve(-1, w);
    chk("timeout_d_rdata", 64'(d_rdata), 64'd0);

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1'b1; if_addr = {26'h0, 4'($urandom), 2'b00};
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
        d_addr = {26'h0, 4'($urandom), 2'b00}; d_wdata = $urandom;
      end
      if (!if_req && !d_req) idle_cycle();
      else serve(($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 7)), w);
    end

    // Reset in the middle of BUSY
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h30; d_wdata = 32'h12345678;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (m_req !== 1'b1 && n < 8);
      chk("midreset_busy", 64'(m_req), 64'd1);
    end
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    starve_m = 0; exp_if_rdata = 32'h0; exp_d_rdata = 32'h0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h3C;
    serve(1, w);
    chk("after_reset_fetch", 64'(w), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
